// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache. A line is refilled one word at a time over a req/ready port. Defining ICACHE_PERF_EN adds saturating hit/miss counters.
// Latency: a hit returns instr combinationally. A miss stalls for 1 + WORDS cycles, plus one cycle for each memory wait state.
// Backpressure: mem_req and mem_addr hold until mem_ready accepts the beat. icache_stall holds fetch for the whole miss.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcf,
    input  logic        hold,
    input  logic        inval,
    output logic [31:0] instr,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]       state;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_index;
    logic [OFF_W-1:0] beat;
    logic             taint;
    logic [LINES-1:0] valid;

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             in_fill;
    logic             beat_acc;
    logic             last_beat;

    assign off       = pcf[2 +: OFF_W];
    assign idx       = pcf[2 + OFF_W +: IDX_W];
    assign tag       = pcf[31 -: TAG_W];
    assign hit       = valid[idx] && (tag_q[idx] == tag);
    assign in_fill   = (state == ST_FILL);
    assign beat_acc  = in_fill && mem_ready;
    assign last_beat = beat_acc && (beat == OFF_W'(WORDS - 1));

    // A tainted fill still completes, but it leaves its line invalid. The final assignment to valid gives inval priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fill_tag   <= '0;
            fill_index <= '0;
            beat       <= '0;
            taint      <= 1'b0;
            valid      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!hit) begin
                        fill_tag   <= tag;
                        fill_index <= idx;
                        beat       <= '0;
                        taint      <= inval;
                        state      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (inval) begin
                        taint <= 1'b1;
                    end
                    if (mem_ready) begin
                        beat <= beat + OFF_W'(1);
                        if (beat == OFF_W'(WORDS - 1)) begin
                            valid[fill_index] <= !(taint || inval);
                            taint             <= 1'b0;
                            state             <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (inval) begin
                valid <= '0;
            end
        end
    end

    // Data and tags are not reset. The valid bits alone decide whether a line is used.
    always_ff @(posedge clk) begin
        if (reset && beat_acc) begin
            data_q[fill_index][beat] <= mem_rdata;
            if (last_beat) begin
                tag_q[fill_index] <= fill_tag;
            end
        end
    end

    always_comb begin
        instr        = '0;
        icache_stall = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        if (reset) begin
            if (in_fill) begin
                icache_stall = 1'b1;
                mem_req      = 1'b1;
                mem_addr     = {fill_tag, fill_index, beat, 2'b00};
            end else if (hit) begin
                instr = data_q[idx][off];
            end else begin
                icache_stall = 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (!in_fill && hit && !hold && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (!in_fill && !hit && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    logic unused_hold;
    assign unused_hold = hold;
`endif

    logic unused_pcf_lsb;
    assign unused_pcf_lsb = ^pcf[1:0];

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm. It applies a directed vector table, hand sequences for inval and reset, and random fetches.
// Every result is checked against a line-level cache model and an arithmetic memory image.
module tb_icache_dm;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int LINE_BYTES = 4 * WORDS;

    logic        clk = 1'b0;
    logic        reset, hold, inval, mem_ready;
    logic [31:0] pcf, instr, mem_addr, mem_rdata;
    logic        icache_stall, mem_req;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    icache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .reset(reset), .pcf(pcf), .hold(hold), .inval(inval),
        .instr(instr), .icache_stall(icache_stall), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef ICACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Multiplying by an odd constant is a bijection, so distinct word addresses return distinct words.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    int tests = 0;
    int fails = 0;

    // The model tracks, per cache slot, the valid state and the memory line number it holds.
    bit          m_valid [LINES];
    int unsigned m_line  [LINES];
    int          exp_hits, exp_misses;
    bit          m_idle_hit;
    int          ready_mode, wcnt;
    logic        prev_req, prev_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        int unsigned line = a / LINE_BYTES;
        return m_valid[line % LINES] && (m_line[line % LINES] == line);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_perf(input string name);
`ifdef ICACHE_PERF_EN
        check({name, "_hits"}, hit_count, exp_hits);
        check({name, "_misses"}, miss_count, exp_misses);
`endif
    endtask

    // One clock: credit the ending cycle to the hit count, then drive mem_ready for the new cycle.
    task automatic step();
        if (reset && m_idle_hit && !hold) exp_hits++;
        prev_req = mem_req;
        prev_rdy = mem_ready;
        @(posedge clk);
        #1;
        if (prev_req && !prev_rdy) wcnt++;
        else wcnt = 0;
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = (wcnt == 2);
            default: mem_ready = ($urandom_range(0, 2) != 0);
        endcase
        #1;
    endtask

    // Present pcf and run until stall drops. inv = -2 asserts inval in the miss cycle, and inv >= 0 asserts it on that beat.
    task automatic fetch(input string name, input logic [31:0] a, input int fills,
                         input int exp_stall, input int inv, input bit h, input bit do_step);
        int n, waits, beats;
        bit addr_ok, injected;
        logic [31:0] base;
        if (do_step) step();
        pcf   = a;
        hold  = h;
        inval = (inv == -2);
        #1;
        m_idle_hit = (fills == 0);
        base = a - (a % LINE_BYTES);
        n = 0; waits = 0; beats = 0; addr_ok = 1'b1; injected = (inv == -2);
        if (fills > 0) begin
            check({name, "_miss_stall"}, icache_stall, 1'b1);
            check({name, "_miss_req"}, mem_req, 1'b0);
            check({name, "_miss_instr"}, instr, 32'h0);
        end
        while (icache_stall && n < 400) begin
            n++;
            if (mem_req) begin
                if (mem_addr !== base + 32'(4 * (beats % WORDS))) addr_ok = 1'b0;
                if (inv >= 0 && !injected && beats == inv) begin
                    inval = 1'b1;
                    injected = 1'b1;
                end
                if (mem_ready) beats++;
                else waits++;
            end
            step();
            inval = 1'b0;
        end
        m_idle_hit = 1'b1;
        check({name, "_stall_cycles"}, n, (exp_stall < 0) ? fills * (WORDS + 1) + waits : exp_stall);
        check({name, "_beats"}, beats, fills * WORDS);
        check({name, "_addr_seq"}, addr_ok, 1'b1);
        check({name, "_instr"}, instr, mem_fn(a & 32'hFFFF_FFFC));
        check({name, "_idle_req"}, mem_req, 1'b0);
        exp_misses += fills;
        if (inv != -1) m_clear();
        if (fills > 0) begin
            m_valid[(a / LINE_BYTES) % LINES] = 1'b1;
            m_line[(a / LINE_BYTES) % LINES]  = a / LINE_BYTES;
        end
    endtask

    task automatic do_inval();
        inval = 1'b1;
        m_clear();
    endtask

    typedef struct {
        logic [31:0] a;
        int          fills;
        int          stall;
        int          inv;
        int          mode;
        bit          h;
        bit          inv_after;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h0000_0040, 1, 5,  -1, 0, 1'b0, 1'b0};
        tbl[1]  = '{32'h0000_0044, 0, 0,  -1, 0, 1'b0, 1'b0};
        tbl[2]  = '{32'h0000_0048, 0, 0,  -1, 0, 1'b0, 1'b0};
        tbl[3]  = '{32'h0000_004C, 0, 0,  -1, 0, 1'b1, 1'b0};
        tbl[4]  = '{32'h0000_0440, 1, 5,  -1, 0, 1'b0, 1'b0};
        tbl[5]  = '{32'h0000_0040, 1, 5,  -1, 0, 1'b0, 1'b0};
        tbl[6]  = '{32'h0000_0100, 1, 13, -1, 1, 1'b0, 1'b0};
        tbl[7]  = '{32'h0000_010C, 0, 0,  -1, 1, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_0080, 2, 10,  2, 0, 1'b0, 1'b0};
        tbl[9]  = '{32'h0000_0084, 0, 0,  -1, 0, 1'b0, 1'b1};
        tbl[10] = '{32'h0000_0088, 1, 5,  -1, 0, 1'b0, 1'b0};
        tbl[11] = '{32'h0000_0040, 1, 5,  -1, 0, 1'b1, 1'b0};
        tbl[12] = '{32'h0000_00C0, 2, 10, -2, 0, 1'b0, 1'b0};
        tbl[13] = '{32'h0000_01C4, 2, 10,  3, 0, 1'b0, 1'b0};
        tbl[14] = '{32'h0000_01C0, 0, 0,  -1, 0, 1'b0, 1'b0};
        tbl[15] = '{32'h0000_00C0, 1, 5,  -1, 0, 1'b0, 1'b0};
        tbl[16] = '{32'h0000_0043, 1, 5,  -1, 0, 1'b0, 1'b0};

        reset = 1'b0; pcf = '0; hold = 1'b0; inval = 1'b0; mem_ready = 1'b0;
        ready_mode = 0; wcnt = 0; exp_hits = 0; exp_misses = 0; m_idle_hit = 1'b0;
        m_clear();
        step();
        step();
        check("rst_req", mem_req, 1'b0);
        check("rst_stall", icache_stall, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check_perf("rst");
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            ready_mode = tbl[i].mode;
            fetch($sformatf("vec%0d", i), tbl[i].a, tbl[i].fills, tbl[i].stall,
                  tbl[i].inv, tbl[i].h, i != 0);
            if (i == 3) check_perf("seq_hits");
            if (tbl[i].inv_after) do_inval();
        end
        check_perf("table");

        ready_mode = 2;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
            fetch("rnd", a, m_hit(a) ? 0 : 1, -1, -1, 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 9) == 0) do_inval();
        end
        check_perf("random");

        // Reset arrives while beat 1 is on the bus. mem_ready is still high, so the post-reset response is stray.
        ready_mode = 0;
        step();
        pcf = 32'h0000_0200; hold = 1'b0; inval = 1'b0;
        m_idle_hit = 1'b0;
        #1;
        check("midrst_miss", icache_stall, 1'b1);
        step();
        step();
        check("midrst_beat1_addr", mem_addr, 32'h0000_0204);
        reset = 1'b0;
        step();
        m_clear();
        exp_hits = 0;
        exp_misses = 0;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_stall", icache_stall, 1'b0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        check_perf("midrst");
        step();
        reset = 1'b1;
        fetch("post_rst", 32'h0000_0040, 1, 5, -1, 1'b0, 1'b0);
        fetch("post_rst_200", 32'h0000_0208, 1, 5, -1, 1'b0, 1'b1);
        check_perf("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the fetch-stage PC (PCF) and a slower word-wide backing instruction memory. It returns InstrF combinationally on a hit. On a miss it raises a stall toward the hazard unit and fills the whole line with a sequential-word FSM over a req/ready handshake. Hazard-unit StallF and StallD are ORed with `icache_stall` upstream.

## Interface
Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2)
- WORDS, 4, 32-bit words per line (power of 2, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- pcf  in  32  fetch PC; bits [1:0] ignored
- hold  in  1  fetch stalled by hazard unit (StallF); suppresses perf counting only
- inval  in  1  invalidate all lines
- instr  out  32  instruction word for pcf (InstrF)
- icache_stall  out  1  miss or fill in progress
- mem_req  out  1  backing-memory word request
- mem_addr  out  32  word-aligned request address
- mem_ready  in  1  beat accepted; mem_rdata valid this cycle
- mem_rdata  in  32  returned word
- hit_count, miss_count  out  32 each  only with ICACHE_PERF_EN

## Operation
- Address split: offset = pcf[2+log2(WORDS)-1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: data array LINES×WORDS×32, tag array, and valid bit per line. All are flops; the read path is combinational.
- hit = valid[index] && tag[index]==tag(pcf).
- States: IDLE and FILL.
- IDLE:
  - hit → instr = data[index][offset], icache_stall=0.
  - miss → icache_stall=1, instr=0. Latch fill tag/index and set beat counter=0. Next state is FILL.
- FILL:
  - icache_stall=1 and mem_req=1.
  - mem_addr = {fill_tag, fill_index, beat, 2'b00}.
  - On mem_ready: write mem_rdata to data[fill_index][beat] and increment beat.
  - On mem_ready with beat==WORDS-1: write the tag, set valid unless the fill is tainted, clear taint, and go to IDLE.
  - mem_req stays high until each beat is accepted. Address changes only after a mem_ready cycle.
- The fill always fetches words 0..WORDS-1 in order. There is no critical-word-first and no abort.
- pcf changes during FILL are ignored. The fill completes with the latched address, then the lookup repeats on the current pcf.
- inval:
  - Clears all valid bits next edge.
  - If asserted while in FILL, or in the IDLE cycle that detects the miss, the fill is tainted. A tainted fill completes but its line is left invalid, so the next lookup misses again.
- A simultaneous inval and final beat also taints the line; inval has priority.
- mem_ready outside FILL is ignored.

## Timing
- Hit latency: 0 cycles (combinational from pcf).
- Miss, zero-wait memory (mem_ready tied high):
  - cycle 0: miss detected.
  - cycles 1..WORDS: beats.
  - cycle WORDS+1: IDLE hit, stall=0.
  - Penalty: WORDS+1 stall cycles.
- Each wait state on mem_ready adds one cycle per beat.
- Reset (reset==0 at edge):
  - Valid bits cleared, state→IDLE, beat=0, taint=0, counters=0.
  - Held outputs while in reset: mem_req=0, mem_addr=0, icache_stall=0, instr=0.
  - Data and tag arrays are not cleared.
- Reset mid-FILL: the fill is abandoned immediately. mem_req drops the cycle after the edge. Late mem_ready is ignored.
- First cycle after reset release: lookup misses (all invalid), icache_stall=1.

## Configuration
- ICACHE_PERF_EN defined:
  - hit_count increments in any IDLE cycle with hit && !hold.
  - miss_count increments on each IDLE→FILL transition.
  - Both saturate at 32'hFFFF_FFFF, and both are cleared by reset.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Cold miss, zero-wait mem, pcf=0x0000_0040: mem_addr sequence is 0x40, 0x44, 0x48, 0x4C. icache_stall is high for exactly 5 cycles. Cycle 6 returns instr = the word loaded at beat 0.
- Sequential hits: after that fill, pcf=0x44, 0x48, 0x4C returns the stored words with stall=0 and no mem_req. With PERF, hit_count=4 and miss_count=1.
- Conflict miss: pcf=0x440 (same index 4, different tag) refills line 4. A subsequent pcf=0x40 misses again.
- Wait states: mem_ready high only every 3rd cycle. mem_addr holds during the idle cycles, and the stall lasts 1+3×4=13 cycles.
- inval during beat 2 of the fill for 0x80: the fill completes (4 beats), then the next cycle misses and refetches 0x80. Separately, inval in IDLE after a fill makes all lines miss.
- reset pulse at beat 1 of a fill: next cycle mem_req=0 and stall=0 during reset. A stray mem_ready is ignored. After release, pcf=0x40 misses and refetches from 0x40.
